// File: rtl/maxpool_2x2_stage.sv
// 2x2 stride-2 signed max-pool over a row-major streamed feature map.
// Results are collected into one parallel vector and offered with valid/ready.
module maxpool_2x2_stage #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 6,
    parameter int IN_H   = 6
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [DATA_W-1:0]                in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_W*(IN_W/2)*(IN_H/2)-1:0]     pool_out,
    output logic                                    busy
);

    localparam int HW = IN_W / 2;
    localparam int HH = IN_H / 2;
    localparam int NW = HW * HH;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             col_q;
    logic [RW-1:0]             row_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      busy_q;
    logic signed [DATA_W-1:0]  held_q;
    logic signed [DATA_W-1:0]  linebuf_q [HW];
    logic signed [DATA_W-1:0]  pool_q    [NW];

    logic                      beat;
    logic                      last_col;
    logic                      last_row;
    logic [LW-1:0]             lb_idx;
    logic [KW-1:0]             pool_idx;
    logic signed [DATA_W-1:0]  pair_max;
    logic signed [DATA_W-1:0]  quad_max;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        beat     = (state_q == COLLECT) && in_valid;
        last_col = (col_q == CW'(IN_W - 1));
        last_row = (row_q == RW'(IN_H - 1));
        lb_idx   = LW'(col_q >> 1);
        pool_idx = KW'(row_q >> 1) * KW'(HW) + KW'(col_q >> 1);
        pair_max = smax(held_q, in_data);
        quad_max = smax(linebuf_q[lb_idx], pair_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            held_q      <= '0;
            for (int i = 0; i < HW; i++) linebuf_q[i] <= '0;
            for (int i = 0; i < NW; i++) pool_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= COLLECT;
                        col_q      <= '0;
                        row_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (beat) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q       <= '0;
                                state_q     <= DONE;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase

            // Even column parks the left pixel; odd column resolves the pair,
            // which the upper row stores and the lower row folds into the result.
            if (beat) begin
                if (!col_q[0]) begin
                    held_q <= in_data;
                end else if (!row_q[0]) begin
                    linebuf_q[lb_idx] <= pair_max;
                end else begin
                    pool_q[pool_idx] <= quad_max;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    for (genvar k = 0; k < NW; k++) begin : g_pack
        assign pool_out[DATA_W*k +: DATA_W] = pool_q[k];
    end

endmodule

// File: tb/tb_maxpool_2x2_stage.sv
// Randomized self-checking bench for maxpool_2x2_stage against a 2x2 block-max model.
module tb_maxpool_2x2_stage;

    localparam int DATA_W = 32;
    localparam int IN_W   = 6;
    localparam int IN_H   = 6;
    localparam int HW     = IN_W / 2;
    localparam int NW     = HW * (IN_H / 2);
    localparam int NPIX   = IN_W * IN_H;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATA_W-1:0]    in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W*NW-1:0]        pool_out;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    logic signed [DATA_W-1:0] pix [NPIX];
    int ramp_exp [NW] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int neg_exp  [NW] = '{0, -2, -4, -12, -14, -16, -24, -26, -28};

    maxpool_2x2_stage #(.DATA_W(DATA_W), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pool_out  (pool_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DATA_W-1:0] model_word(input int k);
        int br = k / HW;
        int bc = k % HW;
        logic signed [DATA_W-1:0] m = pix[2*br*IN_W + 2*bc];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (pix[(2*br+dr)*IN_W + 2*bc+dc] > m) m = pix[(2*br+dr)*IN_W + 2*bc+dc];
        return m;
    endfunction

    function automatic logic signed [DATA_W-1:0] word(input int k);
        return pool_out[DATA_W*k +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds the first n pixels of pix; optional gaps and a stray start mid-frame.
    task automatic run_frame(input int n, input bit stalls, input bit start_mid, output bit rdy_drop);
        int t;
        rdy_drop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collect_entry in_ready=%b busy=%b required 1/1", in_ready, busy);
        end
        for (int i = 0; i < n; i++) begin
            if (stalls) begin
                int gap = (i % 2 == 1) ? 1 : 0;
                if ($urandom_range(0, 4) == 0) gap += 3;
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    tick();
                    if (in_ready !== 1'b1) rdy_drop = 1'b1;
                end
            end
            in_valid = 1'b1;
            in_data  = pix[i];
            if (start_mid && i == 10) start = 1'b1;
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                tick();
                t++;
            end
            if (t == 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout pixel=%0d in_ready=%b required 1", i, in_ready);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic load_ramp(input bit negate);
        for (int i = 0; i < NPIX; i++) pix[i] = negate ? -i : i;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 32'sd77; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b required 0/0/0", in_ready, out_valid, busy);
        end
        checks++;
        if (pool_out !== '0) begin
            errors++;
            $display("FAIL reset_pool pool_out=%h required 0", pool_out);
        end
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_valid in_ready=%b busy=%b required 0/0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_ramp();
        bit d;
        load_ramp(1'b0);
        run_frame(NPIX, 1'b0, 1'b0, d);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ramp_latency out_valid=%b in_ready=%b busy=%b required 1/0/1", out_valid, in_ready, busy);
        end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== DATA_W'(ramp_exp[k])) begin
                errors++;
                $display("FAIL ramp_word%0d got %0d required %0d", k, word(k), ramp_exp[k]);
            end
        end
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ramp_hold out_valid=%b required 1", out_valid);
        end
        ack();
    endtask

    task automatic test_negatives();
        bit d;
        int off = $urandom_range(0, 3);
        for (int i = 0; i < NPIX; i++) pix[i] = -100;
        for (int k = 0; k < NW; k++) begin
            int c = (k + off) % 4;
            pix[(2*(k/HW) + c/2)*IN_W + 2*(k%HW) + c%2] = -5;
        end
        run_frame(NPIX, 1'b0, 1'b0, d);
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== -32'sd5) begin
                errors++;
                $display("FAIL neg_corner_word%0d got %0d required -5", k, word(k));
            end
        end
        ack();
        for (int i = 0; i < NPIX; i++) pix[i] = -1;
        run_frame(NPIX, 1'b0, 1'b0, d);
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== -32'sd1) begin
                errors++;
                $display("FAIL neg_ones_word%0d got %0d required -1", k, word(k));
            end
        end
        ack();
    endtask

    task automatic test_random();
        bit d;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NPIX; i++) pix[i] = $urandom;
            run_frame(NPIX, 1'b0, 1'b0, d);
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (word(k) !== model_word(k)) begin
                    errors++;
                    $display("FAIL random%0d_word%0d got %0d required %0d", r, k, word(k), model_word(k));
                end
            end
            ack();
        end
    endtask

    task automatic test_stalls();
        bit drop;
        load_ramp(1'b0);
        run_frame(NPIX, 1'b1, 1'b0, drop);
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready dropped=%b required 0", drop);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_latency out_valid=%b required 1", out_valid);
        end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== DATA_W'(ramp_exp[k])) begin
                errors++;
                $display("FAIL stall_word%0d got %0d required %0d", k, word(k), ramp_exp[k]);
            end
        end
        ack();
    endtask

    task automatic test_handshake();
        bit d;
        for (int i = 0; i < NPIX; i++) pix[i] = $urandom;
        run_frame(NPIX, 1'b0, 1'b1, d);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL done_hold cycle=%0d out_valid=%b in_ready=%b required 1/0", c, out_valid, in_ready);
            end
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (word(k) !== model_word(k)) begin
                    errors++;
                    $display("FAIL done_word%0d cycle=%0d got %0d required %0d", k, c, word(k), model_word(k));
                end
            end
            tick();
        end
        start = 1'b0;
        ack();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle out_valid=%b busy=%b in_ready=%b required 0/0/0", out_valid, busy, in_ready);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore in_ready=%b busy=%b required 0/0", in_ready, busy);
        end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== model_word(k)) begin
                errors++;
                $display("FAIL retain_word%0d got %0d required %0d", k, word(k), model_word(k));
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit d;
        load_ramp(1'b0);
        run_frame(20, 1'b0, 1'b0, d);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || pool_out !== '0) begin
            errors++;
            $display("FAIL midreset in_ready=%b out_valid=%b busy=%b pool_out=%h required all 0",
                     in_ready, out_valid, busy, pool_out);
        end
        tick();
        run_frame(NPIX, 1'b0, 1'b0, d);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_refill out_valid=%b required 1", out_valid);
        end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== DATA_W'(ramp_exp[k])) begin
                errors++;
                $display("FAIL midreset_word%0d got %0d required %0d", k, word(k), ramp_exp[k]);
            end
        end
        ack();
    endtask

    task automatic test_back_to_back();
        bit d;
        load_ramp(1'b0);
        run_frame(NPIX, 1'b0, 1'b0, d);
        checks++;
        if (word(NW-1) !== DATA_W'(ramp_exp[NW-1])) begin
            errors++;
            $display("FAIL b2b_a_last got %0d required %0d", word(NW-1), ramp_exp[NW-1]);
        end
        ack();
        load_ramp(1'b1);
        run_frame(NPIX, 1'b0, 1'b0, d);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_b_valid out_valid=%b required 1", out_valid);
        end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (word(k) !== DATA_W'(neg_exp[k])) begin
                errors++;
                $display("FAIL b2b_word%0d got %0d required %0d", k, word(k), neg_exp[k]);
            end
        end
        ack();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_negatives();
        test_random();
        test_stalls();
        test_handshake();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2_stage.md
Name: maxpool_2x2_stage

Overview:
- 2x2 stride-2 signed max-pool stage between the convolution engine and the fully connected layer.
- Accepts a conv feature map streamed row-major, one pixel per accepted beat.
- Reduces the map to (IN_W/2)x(IN_H/2) maxima and presents them as one parallel word vector with a valid/ready handshake.
- out_valid drives the FC layer enable; with defaults (6x6 in) it produces the 9 words the FC layer consumes.

Parameters:
DATA_W, 32, width of each signed pixel word
IN_W, 6, input feature-map width in pixels; must be even and >= 2
IN_H, 6, input feature-map height in pixels; must be even and >= 2

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; begins a new frame when idle
in_valid  input  1  in_data carries a pixel this cycle
in_ready  output  1  stage accepts pixels; a beat transfers when in_valid & in_ready
in_data  input  DATA_W  signed pixel, row-major, column fastest
out_valid  output  1  pooled vector complete and stable
out_ready  input  1  consumer acknowledges the pooled vector
pool_out  output  DATA_W*(IN_W/2)*(IN_H/2)  pooled words; word k at [DATA_W*k +: DATA_W], k = (row/2)*(IN_W/2) + col/2
busy  output  1  high in COLLECT or DONE

Behaviour:
- Reset values: state IDLE, in_ready=0, out_valid=0, busy=0, pool_out=0, row/col counters=0, line buffer=0, held pixel=0.
- Reset mid-frame aborts the frame and clears all state; no partial output is ever flagged valid.
- States and transitions:
  - IDLE: in_ready=0. start=1 -> COLLECT next cycle, counters cleared. in_valid is ignored.
  - COLLECT: in_ready=1. Each accepted beat advances col; col wraps IN_W-1 -> 0 and increments row. The beat at row=IN_H-1, col=IN_W-1 -> DONE next cycle. start is ignored.
  - DONE: in_ready=0, out_valid=1. out_ready=1 -> IDLE next cycle, out_valid=0. pool_out holds its value until it is overwritten by the next frame. start is ignored until IDLE.
- in_valid gaps are allowed in COLLECT; counters and state hold during gaps.
- Datapath, per accepted beat:
  - Even col: latch pixel into held register.
  - Odd col: pair = signed max(held, pixel).
  - Even row, odd col: linebuf[col/2] <= pair. The line buffer holds IN_W/2 words.
  - Odd row, odd col: pool_out word k <= signed max(linebuf[col/2], pair).
- All comparisons are signed two's complement. Ties select either operand; the values are equal.
- No arithmetic widening; output words are DATA_W wide.
- Latency: out_valid rises the cycle after the final pixel is accepted. All words are final at that edge.
- out_ready while not in DONE is ignored.
- Throughput: one pixel per cycle. Frame-to-frame gap of at least 2 cycles (DONE->IDLE, start).
- Implementation must elaborate for any legal even IN_W/IN_H.

Test Plan:
- Ramp: start, then in_data 0..35 back-to-back, out_ready=0 -> out_valid rises 1 cycle after pixel 35 and stays high. pool_out words 0..8 = 7,9,11,19,21,23,31,33,35.
- Negatives: all pixels -100 except one -5 at a distinct corner of each 2x2 block -> all 9 words = -5. Also all pixels -1 -> all words -1 (signed compare check).
- Stalls: ramp data with in_valid deasserted on alternating cycles plus random 3-cycle gaps -> identical result to ramp; in_ready stays 1 throughout COLLECT.
- Handshake: in DONE hold out_ready=0 for 5 cycles -> out_valid and pool_out stable. Pulse out_ready -> IDLE next cycle; pool_out retained. start pulsed during COLLECT/DONE and in_valid in IDLE -> no effect.
- Reset mid-frame: assert rst after 20 pixels -> next cycle all outputs and counters are zero, state IDLE. A new full ramp frame then yields the correct 9 words.
- Back-to-back frames: frame A ramp, ack, frame B = ramp negated (0..-35) -> B words 0,-2,-4,-12,-14,-16,-24,-26,-28; no residue from A.
